// File: rtl/ysyx_22040759_alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift/compare plus iterative
// shift-add multiply and restoring divide, with valid/ready on both sides.
module ysyx_22040759_alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [SHW-1:0]     cnt_q;
   logic               is_div_q, sel_hi_q;
   logic [WIDTH-1:0]   a_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   result_q;

   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   sc_res;
   logic               is_iter;
   logic [WIDTH:0]     mul_sum, div_shl, div_diff;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   fin_res;

   assign shamt = src2[SHW-1:0];

   always_comb begin
      sc_res = '0;
      case (alu_op)
         4'd0:  sc_res = src1 + src2;
         4'd1:  sc_res = src1 - src2;
         4'd2:  sc_res = src1 & src2;
         4'd3:  sc_res = src1 | src2;
         4'd4:  sc_res = src1 ^ src2;
         4'd5:  sc_res = src1 << shamt;
         4'd6:  sc_res = src1 >> shamt;
         4'd7:  sc_res = $unsigned($signed(src1) >>> shamt);
         4'd8:  sc_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
         4'd9:  sc_res = {{(WIDTH-1){1'b0}}, src1 < src2};
         // Only reached on the single-cycle divide-by-zero path
         4'd12: sc_res = '1;
         4'd13: sc_res = src1;
         default: sc_res = '0;
      endcase
   end

   assign is_iter = (alu_op == 4'd10) || (alu_op == 4'd11) ||
                    (((alu_op == 4'd12) || (alu_op == 4'd13)) && (src2 != '0));

   // Multiply: acc = {partial product, remaining multiplier}, shift right each step.
   // Divide:   acc = {remainder, dividend/quotient}, shift left each step.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){acc_q[0]}});
      div_shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = div_shl - {1'b0, a_q};
      if (!is_div_q)
         acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
         acc_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         acc_nxt = {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      fin_res = sel_hi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (in_valid) state_d = is_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sel_hi_q <= 1'b0;
         a_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else if (!flush) begin
         if (state_q == S_IDLE && in_valid) begin
            if (is_iter) begin
               is_div_q <= alu_op[2];
               sel_hi_q <= alu_op[0];
               a_q      <= alu_op[2] ? src2 : src1;
               acc_q    <= {{WIDTH{1'b0}}, (alu_op[2] ? src1 : src2)};
               cnt_q    <= SHW'(WIDTH - 1);
            end else begin
               result_q <= sc_res;
            end
         end else if (state_q == S_BUSY) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) result_q <= fin_res;
         end
      end
   end

   assign result = result_q;

endmodule
